// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR / moving-average datapath.
// Used by the stimulus generator, the averager and the display stage.
package fir_pkg;

    localparam int SAMPLE_W = 8;
    localparam int LFSR_W   = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    // Right-shift Galois step; taps fold in when the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr_sample_gen_if.sv
// Output bundle of the stimulus stage: run state, start strobe,
// sample stream and sample counter.
interface lfsr_sample_gen_if #(
    parameter int COUNT_W = 35
);
    import fir_pkg::*;

    logic                enable;
    logic                start_pulse;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic [COUNT_W-1:0]  sample_count;

    modport master (
        output enable,
        output start_pulse,
        output sample,
        output sample_valid,
        output sample_count
    );

    modport slave (
        input enable,
        input start_pulse,
        input sample,
        input sample_valid,
        input sample_count
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// one-cycle pulse on each accepted press (debounced 1->0 edge).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the raw button into the clock domain; idle level is high.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it differed for the full window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state plus a delayed copy for edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press_pulse = prev_q & ~level_q;

endmodule

// File: rtl/lfsr_sample_gen.sv
// Stimulus stage: button-controlled run/stop, start strobe, and a
// divided-rate stream of LFSR samples with a saturating counter.
module lfsr_sample_gen
    import fir_pkg::*;
#(
    parameter int                SAMPLE_DIV      = 5000000,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter logic [LFSR_W-1:0] SEED            = 16'hACE1,
    parameter int                COUNT_W         = 35
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  toggleBtn,
    lfsr_sample_gen_if.master     out_if
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic press;

    run_state_e          state_q;
    run_state_e          state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LFSR_W-1:0]   lfsr_d;
    logic [LFSR_W-1:0]   lfsr_next;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                valid_q;
    logic                valid_d;
    logic                start_q;
    logic                start_d;
    logic [COUNT_W-1:0]  count_q;
    logic [COUNT_W-1:0]  count_d;
    logic                wrap;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .btn_raw     (toggleBtn),
        .press_pulse (press)
    );

    assign lfsr_next = lfsr_step(lfsr_q);
    assign wrap      = (div_q == DIV_LAST);

    // Run/stop FSM and sample datapath; a press outranks a divider wrap.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        div_d    = div_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        start_d  = 1'b0;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    lfsr_d  = SEED;
                    div_d   = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (press) begin
                    state_d = IDLE;
                end else begin
                    div_d = wrap ? '0 : div_q + 1'b1;
                    if (lfsr_q == '0) begin
                        lfsr_d = SEED;
                    end else if (wrap) begin
                        lfsr_d   = lfsr_next;
                        sample_d = lfsr_next[SAMPLE_W-1:0];
                        valid_d  = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            div_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            div_q    <= div_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            count_q  <= count_d;
        end
    end

    assign out_if.enable       = (state_q == RUN);
    assign out_if.start_pulse  = start_q;
    assign out_if.sample       = sample_q;
    assign out_if.sample_valid = valid_q;
    assign out_if.sample_count = count_q;

endmodule
